// File: rtl/led_pkg.sv
// Shared types and constants for the LED display arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        URGENT = 2'd2
    } arb_state_e;

    localparam int SEG_DIGITS = 8;
    localparam int SEG_BITS   = 32;

    // Width of a source index; at least one bit so a single-source build still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_display_arbiter_if.sv
// Request/display bundle between the debug sources and the LED display arbiter.
// Latency: n/a (wires only).
// Backpressure: none; requests are levels and the display is sampled every cycle.
interface led_display_arbiter_if #(
    parameter int NUM_SRC = 4
);
    import led_pkg::*;

    localparam int OW = idx_width(NUM_SRC);

    logic [NUM_SRC-1:0]            req;
    logic [NUM_SRC-1:0]            urgent;
    logic [NUM_SRC*SEG_BITS-1:0]   src_value;
    logic [NUM_SRC*SEG_DIGITS-1:0] src_enable;
    logic [NUM_SRC-1:0]            grant;
    logic [OW-1:0]                 owner;
    logic                          owner_valid;
    logic [SEG_BITS-1:0]           value;
    logic [SEG_DIGITS-1:0]         enable;

    // Source side: drives requests and display buses, observes the grant.
    modport master (
        output req, urgent, src_value, src_enable,
        input  grant, owner, owner_valid, value, enable
    );

    // Arbiter side.
    modport slave (
        input  req, urgent, src_value, src_enable,
        output grant, owner, owner_valid, value, enable
    );

endinterface

// File: rtl/led_display_arbiter_rr_pick.sv
// Round-robin search: first set request at or after start, wrapping past the top.
// Latency: combinational.
// Backpressure: none.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int OW      = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [OW-1:0]      start,
    output logic               found,
    output logic [OW-1:0]      idx
);

    localparam logic [OW:0] N_L = (OW+1)'(NUM_SRC);

    logic [OW:0]   pos;
    logic [OW-1:0] pos_idx;

    // Scan from the farthest offset down so the nearest hit to start wins.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos     = '0;
        pos_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (OW+1)'(k);
            if (pos >= N_L) begin
                pos = pos - N_L;
            end
            pos_idx = pos[OW-1:0];
            if (req[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/led_display_arbiter.sv
// Shares one 8-digit LED driver between debug sources: round-robin turns, urgent preemption with blink.
// Latency: request -> grant 1 cycle; grant -> value/enable 1 further cycle (one register stage).
// Backpressure: none; level requests are re-evaluated every cycle and the display is always driven.
module led_display_arbiter
    import led_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 21_000_000,
    parameter int BLINK_CYCLES = 5_250_000
) (
    input logic                  clk,
    input logic                  reset,
    led_display_arbiter_if.slave bus
);

    localparam int OW = idx_width(NUM_SRC);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [OW-1:0] LAST_SRC   = OW'(NUM_SRC - 1);

    arb_state_e    state, state_nxt;
    logic [OW-1:0] cur_owner, owner_nxt;
    logic [OW-1:0] rr_ptr, rr_ptr_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic [BW-1:0] blink, blink_nxt;
    logic          blink_on, blink_on_nxt;

    logic [SEG_BITS-1:0]   disp_value;
    logic [SEG_DIGITS-1:0] disp_enable;

    logic [SEG_BITS-1:0]   src_val [NUM_SRC];
    logic [SEG_DIGITS-1:0] src_en  [NUM_SRC];

    logic [NUM_SRC-1:0] req_eff;
    logic               any_urg;
    logic [OW-1:0]      urg_idx;
    logic               rr_found;
    logic [OW-1:0]      rr_idx;
    logic               rearb;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_val[i] = bus.src_value[SEG_BITS*i +: SEG_BITS];
        assign src_en[i]  = bus.src_enable[SEG_DIGITS*i +: SEG_DIGITS];
    end

    // An urgent source is also a requester, so a lone urgent bit still counts for rotation.
    assign req_eff = bus.req | bus.urgent;
    assign any_urg = |bus.urgent;

    // Urgent priority is fixed: lowest index wins.
    always_comb begin
        urg_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus.urgent[i]) begin
                urg_idx = OW'(i);
            end
        end
    end

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .OW      (OW)
    ) u_rr_pick (
        .req   (req_eff),
        .start (rr_ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Next-state: hold the current owner, or re-arbitrate on drop/preempt/turn expiry.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = cur_owner;
        rr_ptr_nxt   = rr_ptr;
        dwell_nxt    = dwell;
        blink_nxt    = blink;
        blink_on_nxt = blink_on;
        rearb        = 1'b0;

        case (state)
            IDLE: rearb = 1'b1;
            SHOW: begin
                if (any_urg || !req_eff[cur_owner] || dwell == DWELL_LAST) begin
                    rearb = 1'b1;
                end else begin
                    dwell_nxt = dwell + 1'b1;
                end
            end
            URGENT: begin
                // A higher-priority urgent source waits until the current one lets go.
                if (!bus.urgent[cur_owner]) begin
                    rearb = 1'b1;
                end else if (blink == BLINK_LAST) begin
                    blink_nxt    = '0;
                    blink_on_nxt = !blink_on;
                end else begin
                    blink_nxt = blink + 1'b1;
                end
            end
            default: rearb = 1'b1;
        endcase

        if (rearb) begin
            // Every arbitration restarts both counters; blink phase starts lit.
            dwell_nxt    = '0;
            blink_nxt    = '0;
            blink_on_nxt = 1'b1;
            if (any_urg) begin
                state_nxt = URGENT;
                owner_nxt = urg_idx;
            end else if (rr_found) begin
                // Re-picking the sole requester at turn expiry lands here too and restarts its turn.
                state_nxt  = SHOW;
                owner_nxt  = rr_idx;
                rr_ptr_nxt = (rr_idx == LAST_SRC) ? '0 : rr_idx + 1'b1;
            end else begin
                state_nxt = IDLE;
                owner_nxt = '0;
            end
        end
    end

    // State, owner, pointer and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_owner <= '0;
            rr_ptr    <= '0;
            dwell     <= '0;
            blink     <= '0;
            blink_on  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cur_owner <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            dwell     <= dwell_nxt;
            blink     <= blink_nxt;
            blink_on  <= blink_on_nxt;
        end
    end

    // Display register: follows the owner's bus live, blanked when idle or in the blink-off phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_value  <= '0;
            disp_enable <= '0;
        end else if (state != IDLE) begin
            disp_value  <= src_val[cur_owner];
            disp_enable <= src_en[cur_owner] &
                           ((state == URGENT) ? {SEG_DIGITS{blink_on}} : {SEG_DIGITS{1'b1}});
        end else begin
            disp_value  <= '0;
            disp_enable <= '0;
        end
    end

    assign bus.owner_valid = (state != IDLE);
    assign bus.owner       = cur_owner;
    assign bus.grant       = (state != IDLE) ? (NUM_SRC'(1) << cur_owner) : '0;
    assign bus.value       = disp_value;
    assign bus.enable      = disp_enable;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed bench for led_display_arbiter with a cycle-tagged expectation queue.
// Latency: expectations are tagged with the cycle they must appear in.
// Backpressure: none; the monitor samples outputs every falling edge.
module tb_led_display_arbiter;
    import led_pkg::*;

    localparam int N = 4;

    localparam logic [31:0] V0 = 32'h0000_AAA0;
    localparam logic [31:0] V1 = 32'hDEAD_BEEF;
    localparam logic [31:0] V2 = 32'h2222_2222;
    localparam logic [31:0] V3 = 32'h3333_3333;
    localparam logic [7:0]  E0 = 8'h0F;
    localparam logic [7:0]  E1 = 8'hFF;
    localparam logic [7:0]  E2 = 8'hFF;
    localparam logic [7:0]  E3 = 8'hF0;

    typedef struct {
        int          cyc;
        logic [N-1:0] g;
        logic [31:0] v;
        logic [7:0]  e;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   b;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_display_arbiter_if #(.NUM_SRC(N)) bus ();

    led_display_arbiter #(
        .NUM_SRC      (N),
        .DWELL_CYCLES (8),
        .BLINK_CYCLES (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_rng(input int c0, input int c1, input logic [N-1:0] g,
                           input logic [31:0] v, input logic [7:0] e);
        exp_t x;
        for (int c = c0; c <= c1; c++) begin
            x.cyc = c;
            x.g   = g;
            x.v   = v;
            x.e   = e;
            sb.push_back(x);
        end
    endtask

    // Monitor: compare every tagged expectation in the cycle it names.
    initial begin
        exp_t x;
        int   own;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                x = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed cyc%0d: expectation never sampled", x.cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                x = sb.pop_front();
                own = 0;
                for (int i = 0; i < N; i++) if (x.g[i]) own = i;
                checks++;
                if (bus.grant !== x.g || bus.owner_valid !== (x.g != '0) ||
                    (x.g != '0 && int'(bus.owner) != own) ||
                    bus.value !== x.v || bus.enable !== x.e) begin
                    errors++;
                    $display("FAIL out cyc%0d: grant=%b valid=%b owner=%0d value=%h enable=%h, want grant=%b valid=%b owner=%0d value=%h enable=%h",
                             cyc - b, bus.grant, bus.owner_valid, bus.owner, bus.value, bus.enable,
                             x.g, (x.g != '0), own, x.v, x.e);
                end
            end
        end
    end

    // Stimulus: push the whole expected timeline, then drive the matching inputs.
    initial begin
        reset          = 1'b1;
        bus.req        = '0;
        bus.urgent     = '0;
        bus.src_value  = {V3, V2, V1, V0};
        bus.src_enable = {E3, E2, E1, E0};
        b = 8;

        wait_cyc(2);
        reset = 1'b0;

        exp_rng(2,     b,      4'b0000, 32'h0, 8'h00);
        exp_rng(b+1,   b+1,    4'b0010, 32'h0, 8'h00);
        exp_rng(b+2,   b+8,    4'b0010, V1, E1);
        exp_rng(b+9,   b+9,    4'b1000, V1, E1);
        exp_rng(b+10,  b+16,   4'b1000, V3, E3);
        exp_rng(b+17,  b+17,   4'b0001, V3, E3);
        exp_rng(b+18,  b+24,   4'b0001, V0, E0);
        exp_rng(b+25,  b+25,   4'b0010, V0, E0);
        exp_rng(b+26,  b+27,   4'b0010, V1, E1);
        exp_rng(b+28,  b+28,   4'b0100, V1, E1);
        exp_rng(b+29,  b+31,   4'b0100, V2, 8'hFF);
        exp_rng(b+32,  b+34,   4'b0100, V2, 8'h00);
        exp_rng(b+35,  b+36,   4'b0100, V2, 8'hFF);
        exp_rng(b+37,  b+37,   4'b1000, V2, 8'hFF);
        exp_rng(b+38,  b+44,   4'b1000, V3, E3);
        exp_rng(b+45,  b+45,   4'b0001, V3, E3);
        exp_rng(b+46,  b+46,   4'b0001, V0, E0);
        exp_rng(b+47,  b+47,   4'b1000, V0, E0);
        exp_rng(b+48,  b+50,   4'b1000, V3, 8'hF0);
        exp_rng(b+51,  b+53,   4'b1000, V3, 8'h00);
        exp_rng(b+54,  b+54,   4'b0001, V3, 8'hF0);
        exp_rng(b+55,  b+57,   4'b0001, V0, 8'h0F);
        exp_rng(b+58,  b+58,   4'b0100, V0, 8'h00);
        exp_rng(b+59,  b+63,   4'b0100, V2, E2);
        exp_rng(b+64,  b+64,   4'b0000, 32'h0, 8'h00);
        exp_rng(b+65,  b+65,   4'b0100, 32'h0, 8'h00);
        exp_rng(b+66,  b+66,   4'b0100, V2, E2);
        exp_rng(b+67,  b+67,   4'b0000, V2, E2);
        exp_rng(b+68,  b+69,   4'b0000, 32'h0, 8'h00);

        wait_cyc(b);      bus.req    = 4'b0010;
        wait_cyc(b+2);    bus.req    = 4'b1011;
        wait_cyc(b+27);   bus.urgent = 4'b0100;
        wait_cyc(b+36);   bus.urgent = 4'b0000;
        wait_cyc(b+46);   bus.urgent = 4'b1000;
        wait_cyc(b+48);   bus.urgent = 4'b1001;
        wait_cyc(b+53);   bus.urgent = 4'b0001;
        wait_cyc(b+57);   bus.urgent = 4'b0000; bus.req = 4'b1100;
        wait_cyc(b+63);   reset      = 1'b1;
        wait_cyc(b+64);   reset      = 1'b0;
        wait_cyc(b+66);   bus.req    = 4'b0000;
        wait_cyc(b+71);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
